systolic_ws_ctrl: RTL and testbench

- Sequencer for a ROW_NUM x COL_NUM weight-stationary systolic PE array.
- Per job: loads one weight matrix row by row, holds it on the array weight inputs, streams activation vectors into the west edge with per-row skew, and drives the north edge to zero.
- Captures the south edge, removes the per-column skew, and emits one aligned result vector per activation vector.
- Sits between the GEMM tile scheduler (stream side) and the PE array (array side).

---
 rtl/systolic_ws_ctrl.sv | 172 +++++++++++++++++
 tb/tb_systolic_ws_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ws_ctrl.sv
// Sequencer for a weight-stationary systolic PE array: loads the weight matrix, skews
// activation vectors into the west edge and deskews south-edge sums into aligned results.
module systolic_ws_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [CNT_WIDTH-1:0]              num_vecs,
  output logic                              busy,
  output logic                              done,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [DATA_WIDTH*COL_NUM-1:0]     w_row,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic [DATA_WIDTH*ROW_NUM-1:0]     a_data,
  output logic                              res_valid,
  output logic [4*DATA_WIDTH*COL_NUM-1:0]   res_data,
  output logic [DATA_WIDTH-1:0]             weights [0:ROW_NUM-1][0:COL_NUM-1],
  output logic [DATA_WIDTH-1:0]             wests   [0:ROW_NUM-1],
  output logic [4*DATA_WIDTH-1:0]           norths  [0:COL_NUM-1],
  input  logic [4*DATA_WIDTH-1:0]           souths  [0:COL_NUM-1]
);

  localparam int ACC_WIDTH = 4 * DATA_WIDTH;
  localparam int LAT       = ROW_NUM + COL_NUM + 1;
  localparam int VP_LEN    = ROW_NUM + COL_NUM + 1;
  localparam int ROW_CW    = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int DRN_CW    = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  num_vecs_q;
  logic [CNT_WIDTH-1:0]  vec_cnt;
  logic [CNT_WIDTH:0]    vec_cnt_inc;
  logic [ROW_CW-1:0]     row_cnt;
  logic [DRN_CW-1:0]     drn_cnt;
  logic                  w_fire, a_fire, last_vec;
  logic [VP_LEN-1:0]     vpipe;
  logic [ACC_WIDTH-1:0]  res_vec [0:COL_NUM-1];

  assign w_fire      = w_valid & w_ready;
  assign a_fire      = a_valid & a_ready;
  assign vec_cnt_inc = {1'b0, vec_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign last_vec    = (vec_cnt_inc == {1'b0, num_vecs_q});

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    w_ready   = 1'b0;
    a_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && (row_cnt == ROW_CW'(ROW_NUM - 1)))
          state_nxt = (num_vecs_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        a_ready = 1'b1;
        if (a_valid && last_vec) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drn_cnt == DRN_CW'(LAT - 1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      num_vecs_q <= '0;
      row_cnt    <= '0;
      vec_cnt    <= '0;
      drn_cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            num_vecs_q <= num_vecs;
            row_cnt    <= '0;
            vec_cnt    <= '0;
            drn_cnt    <= '0;
          end
        end
        LOAD_W:  if (w_fire) row_cnt <= row_cnt + 1'b1;
        STREAM:  if (a_fire) vec_cnt <= vec_cnt + 1'b1;
        DRAIN:   drn_cnt <= drn_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Weights persist across DONE; only reset or the next job's load overwrites them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROW_NUM; r++)
        for (int c = 0; c < COL_NUM; c++)
          weights[r][c] <= '0;
    end else if (w_fire) begin
      for (int r = 0; r < ROW_NUM; r++)
        if (row_cnt == ROW_CW'(r))
          for (int c = 0; c < COL_NUM; c++)
            weights[r][c] <= w_row[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // vpipe[k] marks a vector issued k cycles ago; it gates south sampling and res_valid.
  always_ff @(posedge clk) begin
    if (reset) vpipe <= '0;
    else       vpipe <= {vpipe[VP_LEN-2:0], a_fire};
  end

  assign res_valid = vpipe[VP_LEN-1];

  for (genvar i = 0; i < ROW_NUM; i++) begin : g_skew
    logic [DATA_WIDTH-1:0] stage [0:i];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) stage[k] <= '0;
      end else begin
        stage[0] <= a_fire ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= i; k++) stage[k] <= stage[k-1];
      end
    end
    assign wests[i] = stage[i];
  end

  for (genvar j = 0; j < COL_NUM; j++) begin : g_deskew
    localparam int DEPTH = COL_NUM - j;
    logic [ACC_WIDTH-1:0] stage [0:DEPTH-1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else begin
        stage[0] <= vpipe[ROW_NUM+j] ? souths[j] : '0;
        for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
    end
    assign res_vec[j] = stage[DEPTH-1];
  end

  always_comb begin
    res_data = '0;
    for (int j = 0; j < COL_NUM; j++) res_data[j*ACC_WIDTH +: ACC_WIDTH] = res_vec[j];
  end

  always_comb begin
    for (int j = 0; j < COL_NUM; j++) norths[j] = '0;
  end

endmodule

// File: tb/tb_systolic_ws_ctrl.sv
// Self-checking bench for systolic_ws_ctrl: a behavioural 2x2 PE array closes the loop and
// results are checked against a plain matrix-vector reference with bench-derived timing.
module tb_systolic_ws_ctrl;
  localparam int DW  = 8;
  localparam int RN  = 2;
  localparam int CN  = 2;
  localparam int CW  = 16;
  localparam int AW  = 4 * DW;
  localparam int LAT = RN + CN + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CW-1:0]     num_vecs;
  logic              busy, done;
  logic              w_valid, w_ready;
  logic [DW*CN-1:0]  w_row;
  logic              a_valid, a_ready;
  logic [DW*RN-1:0]  a_data;
  logic              res_valid;
  logic [AW*CN-1:0]  res_data;
  logic [DW-1:0]     weights [0:RN-1][0:CN-1];
  logic [DW-1:0]     wests   [0:RN-1];
  logic [AW-1:0]     norths  [0:CN-1];
  logic [AW-1:0]     souths  [0:CN-1];

  always #5 clk = ~clk;

  systolic_ws_ctrl #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .res_valid(res_valid), .res_data(res_data),
    .weights(weights), .wests(wests), .norths(norths), .souths(souths)
  );

  // Unreset PE array: activations hop east, partial sums hop south, one register per PE.
  // north_bias models a forced pre-load on the north edge.
  logic [AW-1:0] north_bias = '0;
  logic [DW-1:0] pe_act [0:RN-1][0:CN-1];
  logic [AW-1:0] pe_sum [0:RN-1][0:CN-1];
  logic [DW-1:0] ain    [0:RN-1][0:CN];
  logic [AW-1:0] pin    [0:RN][0:CN-1];

  always_comb begin
    for (int i = 0; i < RN; i++) begin
      ain[i][0] = wests[i];
      for (int j = 0; j < CN; j++) ain[i][j+1] = pe_act[i][j];
    end
    for (int j = 0; j < CN; j++) begin
      pin[0][j] = norths[j] + north_bias;
      for (int i = 0; i < RN; i++) pin[i+1][j] = pe_sum[i][j];
      souths[j] = pin[RN][j];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RN; i++)
      for (int j = 0; j < CN; j++) begin
        pe_act[i][j] <= ain[i][j];
        pe_sum[i][j] <= pin[i][j] + AW'(ain[i][j]) * AW'(weights[i][j]);
      end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int a_ready_seen = 0;
  int last_a_cyc = 0;
  int last_w_cyc = 0;
  int obs_cyc[$];
  int done_cyc[$];
  int exp_cyc[$];
  logic [AW*CN-1:0] obs_dat[$];
  logic [AW*CN-1:0] exp_dat[$];
  logic [DW-1:0] ref_w [0:RN-1][0:CN-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_dat.push_back(res_data);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (a_ready === 1'b1) a_ready_seen++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [AW*CN-1:0] ref_mul(logic [DW*RN-1:0] v);
    logic [AW*CN-1:0] r;
    longint unsigned s;
    r = '0;
    for (int j = 0; j < CN; j++) begin
      s = longint'(north_bias);
      for (int i = 0; i < RN; i++)
        s += longint'(v[i*DW +: DW]) * longint'(ref_w[i][j]);
      r[j*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW*RN-1:0] vec2(int x0, int x1);
    return {DW'(x1), DW'(x0)};
  endfunction

  task automatic clear_obs();
    obs_cyc.delete(); obs_dat.delete(); done_cyc.delete();
    exp_cyc.delete(); exp_dat.delete();
    a_ready_seen = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_job(int n);
    start = 1'b1;
    num_vecs = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_weights();
    bit acc;
    for (int r = 0; r < RN; r++) begin
      acc = 1'b0;
      w_valid = 1'b1;
      for (int c = 0; c < CN; c++) w_row[c*DW +: DW] = ref_w[r][c];
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (w_ready === 1'b1) begin acc = 1'b1; break; end
      end
      if (acc) begin
        last_w_cyc = cyc;
        @(posedge clk); #1;
      end else begin
        n_vec++; n_err++;
        $display("[TB] FAIL w_timeout: w_ready=%b for row %0d, required 1", w_ready, r);
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic send_vec(logic [DW*RN-1:0] v);
    bit acc;
    acc = 1'b0;
    a_valid = 1'b1;
    a_data = v;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_ready === 1'b1) begin acc = 1'b1; break; end
    end
    if (acc) begin
      last_a_cyc = cyc;
      exp_dat.push_back(ref_mul(v));
      exp_cyc.push_back(cyc + LAT);
      @(posedge clk); #1;
    end else begin
      n_vec++; n_err++;
      $display("[TB] FAIL a_timeout: a_ready=%b, required 1", a_ready);
    end
    a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("[TB] FAIL idle_timeout: busy=%b after 300 cycles, required 0", busy);
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_vec++; if (w_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_w_ready: got %b want 0", w_ready); end
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_a_ready: got %b want 0", a_ready); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); end
    n_vec++; if (res_data !== '0) begin n_err++; $display("[TB] FAIL reset_res_data: got %0h want 0", res_data); end
    for (int i = 0; i < RN; i++) begin
      n_vec++; if (wests[i] !== '0) begin n_err++; $display("[TB] FAIL reset_wests%0d: got %0h want 0", i, wests[i]); end
      for (int j = 0; j < CN; j++) begin
        n_vec++;
        if (weights[i][j] !== '0) begin n_err++; $display("[TB] FAIL reset_weights%0d%0d: got %0h want 0", i, j, weights[i][j]); end
      end
    end
    for (int j = 0; j < CN; j++) begin
      n_vec++; if (norths[j] !== '0) begin n_err++; $display("[TB] FAIL reset_norths%0d: got %0h want 0", j, norths[j]); end
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_single();
    clear_obs();
    ref_w = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    start_job(1);
    load_weights();
    send_vec(vec2(5, 6));
    wait_idle();
    n_vec++;
    if (obs_dat.size() != 1) begin n_err++; $display("[TB] FAIL single_count: got %0d results want 1", obs_dat.size()); end
    for (int k = 0; k < obs_dat.size() && k < exp_dat.size(); k++) begin
      n_vec++; if (obs_dat[k] !== exp_dat[k]) begin n_err++; $display("[TB] FAIL single_data: got %0h want %0h", obs_dat[k], exp_dat[k]); end
      n_vec++; if (obs_cyc[k] != exp_cyc[k]) begin n_err++; $display("[TB] FAIL single_cycle: got %0d want %0d", obs_cyc[k], exp_cyc[k]); end
    end
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != last_a_cyc + LAT + 1) begin
      n_err++; $display("[TB] FAIL single_done: got %0d pulses, want 1 at cycle %0d", done_cyc.size(), last_a_cyc + LAT + 1);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    start_job(4);
    load_weights();
    send_vec(vec2(1, 0));
    send_vec(vec2(0, 1));
    send_vec(vec2(1, 1));
    idle(2);
    send_vec(vec2(2, 2));
    wait_idle();
    n_vec++;
    if (obs_dat.size() != 4) begin n_err++; $display("[TB] FAIL b2b_count: got %0d results want 4", obs_dat.size()); end
    for (int k = 0; k < obs_dat.size() && k < exp_dat.size(); k++) begin
      n_vec++; if (obs_dat[k] !== exp_dat[k]) begin n_err++; $display("[TB] FAIL b2b_data%0d: got %0h want %0h", k, obs_dat[k], exp_dat[k]); end
      n_vec++; if (obs_cyc[k] != exp_cyc[k]) begin n_err++; $display("[TB] FAIL b2b_cycle%0d: got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
    end
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != last_a_cyc + LAT + 1) begin
      n_err++; $display("[TB] FAIL b2b_done: got %0d pulses, want 1 at cycle %0d", done_cyc.size(), last_a_cyc + LAT + 1);
    end
  endtask

  task automatic test_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      ref_w = '{'{8'd255, 8'd255}, '{8'd255, 8'd255}};
      north_bias = (pass == 0) ? '0 : 32'hFFFF_FFF0;
      start_job(1);
      load_weights();
      send_vec(vec2(255, 255));
      wait_idle();
      n_vec++;
      if (obs_dat.size() != 1) begin n_err++; $display("[TB] FAIL wrap_count%0d: got %0d results want 1", pass, obs_dat.size()); end
      for (int k = 0; k < obs_dat.size() && k < exp_dat.size(); k++) begin
        n_vec++; if (obs_dat[k] !== exp_dat[k]) begin n_err++; $display("[TB] FAIL wrap_data%0d: got %0h want %0h", pass, obs_dat[k], exp_dat[k]); end
        n_vec++; if (obs_cyc[k] != exp_cyc[k]) begin n_err++; $display("[TB] FAIL wrap_cycle%0d: got %0d want %0d", pass, obs_cyc[k], exp_cyc[k]); end
      end
    end
    north_bias = '0;
    idle(RN + CN + 2);
  endtask

  task automatic test_zero_vecs();
    clear_obs();
    ref_w = '{'{8'd9, 8'd8}, '{8'd7, 8'd6}};
    start_job(0);
    load_weights();
    wait_idle();
    n_vec++; if (obs_dat.size() != 0) begin n_err++; $display("[TB] FAIL zero_res: got %0d results want 0", obs_dat.size()); end
    n_vec++; if (a_ready_seen != 0) begin n_err++; $display("[TB] FAIL zero_a_ready: high %0d cycles want 0", a_ready_seen); end
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != last_w_cyc + 1) begin
      n_err++; $display("[TB] FAIL zero_done: got %0d pulses, want 1 at cycle %0d", done_cyc.size(), last_w_cyc + 1);
    end
  endtask

  task automatic test_ignored_inputs();
    clear_obs();
    ref_w = '{'{8'd7, 8'd9}, '{8'd11, 8'd13}};
    start_job(2);
    load_weights();
    start = 1'b1;
    w_valid = 1'b1;
    w_row = DW*CN'($urandom);
    send_vec(vec2($urandom_range(0, 255), $urandom_range(0, 255)));
    start = 1'b0;
    send_vec(vec2($urandom_range(0, 255), $urandom_range(0, 255)));
    wait_idle();
    w_valid = 1'b0;
    n_vec++;
    if (obs_dat.size() != 2) begin n_err++; $display("[TB] FAIL ign_count: got %0d results want 2", obs_dat.size()); end
    for (int k = 0; k < obs_dat.size() && k < exp_dat.size(); k++) begin
      n_vec++; if (obs_dat[k] !== exp_dat[k]) begin n_err++; $display("[TB] FAIL ign_data%0d: got %0h want %0h", k, obs_dat[k], exp_dat[k]); end
      n_vec++; if (obs_cyc[k] != exp_cyc[k]) begin n_err++; $display("[TB] FAIL ign_cycle%0d: got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
    end
    n_vec++; if (done_cyc.size() != 1) begin n_err++; $display("[TB] FAIL ign_jobs: got %0d done pulses want 1", done_cyc.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL ign_busy: got %b want 0", busy); end
    for (int i = 0; i < RN; i++)
      for (int j = 0; j < CN; j++) begin
        n_vec++;
        if (weights[i][j] !== ref_w[i][j]) begin
          n_err++; $display("[TB] FAIL ign_weights%0d%0d: got %0d want %0d", i, j, weights[i][j], ref_w[i][j]);
        end
      end
  endtask

  task automatic test_reset_mid_job();
    clear_obs();
    ref_w = '{'{8'd3, 8'd1}, '{8'd4, 8'd1}};
    start_job(4);
    load_weights();
    send_vec(vec2(10, 20));
    send_vec(vec2(30, 40));
    idle(1);
    reset = 1'b1;
    clear_obs();
    idle(1);
    reset = 1'b0;
    idle(LAT + 4);
    n_vec++; if (obs_dat.size() != 0) begin n_err++; $display("[TB] FAIL rst_res: got %0d results want 0", obs_dat.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (done_cyc.size() != 0) begin n_err++; $display("[TB] FAIL rst_done: got %0d pulses want 0", done_cyc.size()); end
    for (int i = 0; i < RN; i++)
      for (int j = 0; j < CN; j++) begin
        n_vec++;
        if (weights[i][j] !== '0) begin n_err++; $display("[TB] FAIL rst_weights%0d%0d: got %0d want 0", i, j, weights[i][j]); end
      end
    clear_obs();
    ref_w = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    start_job(1);
    load_weights();
    send_vec(vec2(5, 6));
    wait_idle();
    n_vec++;
    if (obs_dat.size() != 1) begin n_err++; $display("[TB] FAIL rst_new_count: got %0d results want 1", obs_dat.size()); end
    for (int k = 0; k < obs_dat.size() && k < exp_dat.size(); k++) begin
      n_vec++; if (obs_dat[k] !== exp_dat[k]) begin n_err++; $display("[TB] FAIL rst_new_data: got %0h want %0h", obs_dat[k], exp_dat[k]); end
      n_vec++; if (obs_cyc[k] != exp_cyc[k]) begin n_err++; $display("[TB] FAIL rst_new_cycle: got %0d want %0d", obs_cyc[k], exp_cyc[k]); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int job = 0; job < 4; job++) begin
      clear_obs();
      for (int i = 0; i < RN; i++)
        for (int j = 0; j < CN; j++) ref_w[i][j] = DW'($urandom);
      north_bias = (job == 3) ? AW'($urandom) : '0;
      n = $urandom_range(1, 6);
      start_job(n);
      load_weights();
      for (int v = 0; v < n; v++) begin
        idle($urandom_range(0, 2));
        send_vec(vec2($urandom_range(0, 255), $urandom_range(0, 255)));
      end
      wait_idle();
      n_vec++;
      if (obs_dat.size() != n) begin n_err++; $display("[TB] FAIL rnd_count%0d: got %0d results want %0d", job, obs_dat.size(), n); end
      for (int k = 0; k < obs_dat.size() && k < exp_dat.size(); k++) begin
        n_vec++; if (obs_dat[k] !== exp_dat[k]) begin n_err++; $display("[TB] FAIL rnd_data%0d_%0d: got %0h want %0h", job, k, obs_dat[k], exp_dat[k]); end
        n_vec++; if (obs_cyc[k] != exp_cyc[k]) begin n_err++; $display("[TB] FAIL rnd_cycle%0d_%0d: got %0d want %0d", job, k, obs_cyc[k], exp_cyc[k]); end
      end
      n_vec++;
      if (done_cyc.size() != 1 || done_cyc[0] != last_a_cyc + LAT + 1) begin
        n_err++; $display("[TB] FAIL rnd_done%0d: got %0d pulses, want 1 at cycle %0d", job, done_cyc.size(), last_a_cyc + LAT + 1);
      end
    end
    north_bias = '0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    num_vecs = '0;
    w_valid  = 1'b0;
    w_row    = '0;
    a_valid  = 1'b0;
    a_data   = '0;
    repeat (RN + CN + 4) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_zero_vecs();
    test_ignored_inputs();
    test_reset_mid_job();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
